// File: rtl/fp_div_iter.sv
// Iterative restoring radix-2 IEEE-754 divider with valid/ready handshakes.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_div_iter #(
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int PRECISION = 32,
  parameter int BIAS      = 127
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] a_operand,
  input  logic [PRECISION-1:0] b_operand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] result,
  output logic [3:0]           flags
);

  localparam int EW = EXPONENT + 2;
  localparam int QW = FRACTION + 4;
  localparam int RW = FRACTION + 2;
  localparam int CW = $clog2(FRACTION + 4);
  localparam logic [CW-1:0]        LAST   = CW'(FRACTION + 3);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXPONENT) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [PRECISION-1:0] QNAN   = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
`ifdef FP_DIV_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [FRACTION:0]      div_q, div_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [PRECISION-1:0]   result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  logic [EXPONENT-1:0] ea, eb;
  logic [FRACTION-1:0] fa, fb;
  logic                sa, sb, sq;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a_operand;
  assign {sb, eb, fb} = b_operand;
  assign sq     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  // Normalised quotient without its hidden bit: frac | guard | round | extra.
  logic                 norm, inc, sticky;
  logic [QW-2:0]        qn;
  logic signed [EW-1:0] en, er;
  logic [FRACTION:0]    frac_r;

  assign norm   = quo_q[QW-1];
  assign qn     = norm ? quo_q[QW-2:0] : {quo_q[QW-3:0], 1'b0};
  assign en     = norm ? exp_q : exp_q - EW'(1);
  assign sticky = (rem_q != '0) | qn[0];
  assign inc    = RNE & qn[2] & (qn[1] | sticky | qn[3]);
  assign frac_r = {1'b0, qn[QW-2:3]} + {{FRACTION{1'b0}}, inc};
  assign er     = en + {{(EW-1){1'b0}}, frac_r[FRACTION]};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d  = sq;
        flags_d = '0;
        state_d = DONE;
        if (a_nan || b_nan) begin
          result_d = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = QNAN;
          flags_d  = 4'b1000;
        end else if (a_inf) begin
          result_d = {sq, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        end else if (b_zero) begin
          result_d = {sq, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
          flags_d  = 4'b0100;
        end else if (a_zero || b_inf) begin
          result_d = {sq, {(PRECISION-1){1'b0}}};
        end else begin
          rem_d   = {2'b01, fa};
          div_d   = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW'(BIAS);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (rem_q >= {1'b0, div_q}) begin
          quo_d = {quo_q[QW-2:0], 1'b1};
          rem_d = (rem_q - {1'b0, div_q}) << 1;
        end else begin
          quo_d = {quo_q[QW-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        if (cnt_q == LAST) state_d = ROUND;
        else               cnt_d   = cnt_q + CW'(1);
      end
      ROUND: begin
        state_d = DONE;
        if (er >= E_MAX) begin
          result_d = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
          flags_d  = 4'b0010;
        end else if (er <= E_ZERO) begin
          result_d = {sign_q, {(PRECISION-1){1'b0}}};
          flags_d  = 4'b0001;
        end else begin
          result_d = {sign_q, er[EXPONENT-1:0], frac_r[FRACTION-1:0]};
          flags_d  = '0;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = reset_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: special cases, rounding, range limits,
// latency, output backpressure and mid-operation reset.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_assert = 0;
  int n_fail   = 0;

  fp_div_iter #(
    .EXPONENT (8),
    .FRACTION (23),
    .PRECISION(32),
    .BIAS     (127)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_operand(a_operand),
    .b_operand(b_operand),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation with out_ready high and checks result, flags and latency.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
    int cyc;
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    a_operand = 32'hDEADBEEF;
    b_operand = 32'h12345678;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_f});
    step();
    chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] third;
`ifdef FP_DIV_RNE_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_operand = '0;
    b_operand = '0;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    run("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
    run("one_third",   32'h3F800000, 32'h40400000, third,        4'b0000, 29);
    run("neg_six",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29);
    run("one_by_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 29);
    run("div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
    run("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    run("inf_fin",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    run("inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
    run("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
    run("nzero_fin",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1);
    run("fin_inf",     32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1);
    run("subnorm",     32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1);
    run("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 29);
    run("max_exp",     32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 29);
    run("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29);
    run("min_exp",     32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 29);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    a_operand = 32'h40C00000;
    b_operand = 32'h40000000;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && !out_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'h40400000);
      chk("bp_flags", {28'd0, flags}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    run("bp_second", 32'h3F800000, 32'h40400000, third, 4'b0000, 29);

    // Reset during DIVIDE discards the operation.
    a_operand = 32'h40C00000;
    b_operand = 32'h40000000;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    run("after_rst", 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Iterative, handshaked IEEE-754 floating-point divider: the parametrised successor to the fixed-latency single-precision pipelined divider. It computes `a_operand / b_operand` with a restoring radix-2 loop, one quotient bit per cycle, and uses a valid/ready handshake on both sides. It handles zero, infinity and NaN per IEEE-754, flushes subnormals, and reports exception flags. It sits in the chaos-map datapath beside the FP add/mul units and targets area-constrained builds where one shared divider is enough.

## Interface
- `EXPONENT`, 8, exponent field width.
- `FRACTION`, 23, stored fraction width.
- `PRECISION`, 32, total word width; must equal 1+EXPONENT+FRACTION.
- `BIAS`, 127, exponent bias; must equal 2^(EXPONENT-1)-1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider idle and able to accept.
- `a_operand`  in  PRECISION  dividend, IEEE-754.
- `b_operand`  in  PRECISION  divisor, IEEE-754.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  PRECISION  quotient, IEEE-754.
- `flags`  out  4  {invalid, div_by_zero, overflow, underflow}; valid with `out_valid`.

## Operation
- FSM states: IDLE, DIVIDE, ROUND, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, capture both operands and classify them.
  - A special case moves to DONE. Otherwise move to DIVIDE with the loop counter at 0.
- Input classification:
  - An exponent of 0 means the operand is zero. Subnormal inputs are flushed to signed zero and no flag is raised.
  - Exponent all-ones with fraction 0 is infinity. Exponent all-ones with fraction nonzero is NaN.
- Special results (sign = sign_a XOR sign_b unless stated):
  - Either operand NaN → canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0); no flag.
  - 0/0 or inf/inf → canonical qNaN with `invalid`.
  - Finite nonzero/0 → signed inf with `div_by_zero`.
  - 0/finite or finite/inf → signed zero.
  - inf/finite → signed inf.
- DIVIDE:
  - Significands are `{1,frac}` (FRACTION+1 bits). The remainder starts at the dividend significand.
  - Each cycle: if rem >= divisor, emit quotient bit 1 and set rem -= divisor; otherwise emit 0. Then rem <<= 1.
  - The loop runs exactly FRACTION+4 cycles. Sticky = (final rem != 0).
- Exponent: e = exp_a − exp_b + BIAS, held signed in EXPONENT+2 bits.
- ROUND (one cycle):
  - If the quotient MSB is 0, shift the quotient left by 1 and set e -= 1.
  - Take the mantissa, guard and round bits. Rounding is defined under Configuration.
  - A round carry out to 2.0 sets the mantissa to 1.0 and e += 1.
  - e >= 2^EXPONENT−1 → signed inf with `overflow`.
  - e <= 0 → signed zero with `underflow` (flush-to-zero, no subnormal output).
- DONE:
  - `out_valid`=1 while in DONE. `result` and `flags` are held stable.
  - When `out_ready`=1, move to IDLE.
- Operands are registered at the handshake. Changes to the input ports after acceptance are ignored.

## Timing
- Reset value (synchronous, applied whenever `reset_n`=0 at a clock edge) for every output: `in_ready`=0 during reset, `out_valid`=0, `result`=0, `flags`=0.
  - The state is forced to IDLE, so `in_ready` is 1 on the first cycle after release.
- Reset mid-operation (DIVIDE, ROUND or DONE) discards the in-flight result. No `out_valid` is produced for it.
- Latency, counting the handshake cycle as cycle 0:
  - Normal operands: DIVIDE in cycles 1..FRACTION+4, ROUND in cycle FRACTION+5, `out_valid` first high in cycle FRACTION+6 (29 at the defaults).
  - Special cases: `out_valid` high in cycle 1.
- Throughput: one operation in flight. `in_ready`=0 from cycle 1 until the cycle after the output handshake.
- The output handshake completes in the cycle where `out_valid` and `out_ready` are both 1. `in_ready` is 1 in the next cycle.
- With `out_ready` held high, back-to-back normal operations take FRACTION+7 cycles each.

## Configuration
- `FP_DIV_RNE_EN` defined: round-to-nearest-even. Increment when guard=1 and (round|sticky|mantissa LSB)=1.
- `FP_DIV_RNE_EN` undefined: truncate (round toward zero). Guard, round and sticky are still computed and ignored.
- Cycle counts are identical in both builds.

## Test plan
- 0x40C00000 / 0x40000000 → `result` 0x40400000, `flags` 0, `out_valid` exactly 29 cycles after the handshake.
- 0x3F800000 / 0x40400000 → 0x3EAAAAAB with `FP_DIV_RNE_EN`, 0x3EAAAAAA without it; `flags` 0.
- Special cases, each with `out_valid` at cycle 1:
  - 0x3F800000 / 0x00000000 → 0x7F800000, `flags`=0100.
  - 0x00000000 / 0x00000000 → 0x7FC00000, `flags`=1000.
  - 0xFF800000 / 0x40000000 → 0xFF800000, `flags` 0.
- 0x7F000000 / 0x3E800000 → 0x7F800000, `flags`=0010. 0x00800000 / 0x40000000 → 0x00000000, `flags`=0001.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises.
  - `result`, `flags` and `out_valid` stay stable and `in_ready` stays 0.
  - On the `out_ready` pulse, `in_ready` is 1 the next cycle and a second operation is accepted.
- Assert `reset_n`=0 for one cycle at DIVIDE cycle 10. The next cycle shows `out_valid`=0, `result`=0 and `in_ready`=1. A new operation then completes correctly.
